// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths and NOP encoding for the fetch stage
package fetch_unit_pkg;
  localparam int ADDR_W = 32;
  localparam int INSTR_W = 32;
  localparam logic [2:0] FUNCT3_ADD = 3'b000;
  localparam logic [6:0] OPCODE_ITYPE = 7'b0010011;
  localparam logic [INSTR_W-1:0] NOP = {12'h000, 5'd0, FUNCT3_ADD, 5'd0, OPCODE_ITYPE};
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: memory request/response, decode and redirect signals (perf counters under FETCH_PERF_EN)
interface fetch_unit_if import fetch_unit_pkg::*; ();
  logic [ADDR_W-1:0] o_req_addr;
  logic [INSTR_W-1:0] i_res_data;
  logic i_stall;
  logic i_redirect_valid;
  logic [ADDR_W-1:0] i_redirect_addr;
  logic [INSTR_W-1:0] o_instr;
  logic [ADDR_W-1:0] o_instr_pc;
  logic o_instr_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] o_fetch_cnt;
  logic [31:0] o_bubble_cnt;
  modport master(output o_req_addr, o_instr, o_instr_pc, o_instr_valid, o_fetch_cnt, o_bubble_cnt,
                 input i_res_data, i_stall, i_redirect_valid, i_redirect_addr);
  modport slave(input o_req_addr, o_instr, o_instr_pc, o_instr_valid, o_fetch_cnt, o_bubble_cnt,
                output i_res_data, i_stall, i_redirect_valid, i_redirect_addr);
`else
  modport master(output o_req_addr, o_instr, o_instr_pc, o_instr_valid,
                 input i_res_data, i_stall, i_redirect_valid, i_redirect_addr);
  modport slave(input o_req_addr, o_instr, o_instr_pc, o_instr_valid,
                output i_res_data, i_stall, i_redirect_valid, i_redirect_addr);
`endif
endinterface

// File: rtl/fetch_unit_skid_reg.sv
// fetch_skid_reg: one-entry {pc,data} holding register with load and priority clear
module fetch_skid_reg import fetch_unit_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [INSTR_W-1:0] d_data,
  output logic q_v,
  output logic [ADDR_W-1:0] q_pc,
  output logic [INSTR_W-1:0] q_data
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q_v <= 1'b0;
      q_pc <= '0;
      q_data <= NOP;
    end else if (clear) begin
      q_v <= 1'b0;
    end else if (load) begin
      q_v <= 1'b1;
      q_pc <= d_pc;
      q_data <= d_data;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner pairing 1-cycle memory words with their PC, skid on stall, squash on redirect; FETCH_PERF_EN adds counters
module fetch_unit import fetch_unit_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  fetch_unit_if.master f
);
  logic [ADDR_W-1:0] pc_q, if_pc, sk_pc;
  logic if_v, sk_v;
  logic [INSTR_W-1:0] sk_data;
  logic [ADDR_W-1:0] redir_pc;
  assign redir_pc = f.i_redirect_addr & ~ADDR_W'(3);
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      if_v <= 1'b0;
      if_pc <= '0;
    end else if (f.i_redirect_valid) begin
      pc_q <= redir_pc;
      if_v <= 1'b0;
    end else begin
      if_v <= 1'b1;
      if_pc <= pc_q;
      pc_q <= f.i_stall ? pc_q : pc_q + ADDR_W'(4);
    end
  end
  fetch_skid_reg u_skid (
    .clk(clk),
    .reset(reset),
    .load(f.i_stall && !sk_v && if_v),
    .clear(f.i_redirect_valid || !f.i_stall),
    .d_pc(if_pc),
    .d_data(f.i_res_data),
    .q_v(sk_v),
    .q_pc(sk_pc),
    .q_data(sk_data)
  );
  always_comb begin
    f.o_req_addr = pc_q;
    f.o_instr_valid = sk_v | if_v;
    f.o_instr = sk_v ? sk_data : if_v ? f.i_res_data : NOP;
    f.o_instr_pc = sk_v ? sk_pc : if_pc;
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      f.o_fetch_cnt <= '0;
      f.o_bubble_cnt <= '0;
    end else begin
      f.o_fetch_cnt <= f.o_fetch_cnt + 32'(f.o_instr_valid & ~f.i_stall);
      f.o_bubble_cnt <= f.o_bubble_cnt + 32'(~f.o_instr_valid);
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a mem[k]=k+1 one-cycle memory
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fetch_unit_if f0();
  fetch_unit_if f1();
  fetch_unit u0 (.clk(clk), .reset(reset), .f(f0));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (.clk(clk), .reset(reset), .f(f1));
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a[31:2] < 30'd256) ? {2'b00, a[31:2]} + 32'd1 : 32'h0000_0013;
  endfunction
  always @(posedge clk) begin
    f0.i_res_data <= mem_word(f0.o_req_addr);
    f1.i_res_data <= mem_word(f1.o_req_addr);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic exp_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    check({tag, ".valid"}, 32'(f0.o_instr_valid), 32'(v));
    check({tag, ".pc"}, f0.o_instr_pc, pc);
    check({tag, ".instr"}, f0.o_instr, ins);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    f0.i_stall = 1'b0;
    f0.i_redirect_valid = 1'b0;
    f0.i_redirect_addr = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask
  initial begin
    f1.i_stall = 1'b0;
    f1.i_redirect_valid = 1'b0;
    f1.i_redirect_addr = '0;
    do_reset();
    exp_out("rst", 1'b0, 32'h0, 32'h13);
    check("rst.req", f0.o_req_addr, 32'h0);
    check("rst1.req", f1.o_req_addr, 32'hFFFF_FFFC);
    check("rst1.valid", 32'(f1.o_instr_valid), 32'd0);
`ifdef FETCH_PERF_EN
    check("rst.fetch_cnt", f0.o_fetch_cnt, 32'd0);
    check("rst.bubble_cnt", f0.o_bubble_cnt, 32'd0);
`endif
    cyc();
    exp_out("s1c1", 1'b1, 32'h0, 32'd1);
    check("s5c1.valid", 32'(f1.o_instr_valid), 32'd1);
    check("s5c1.pc", f1.o_instr_pc, 32'hFFFF_FFFC);
    check("s5c1.instr", f1.o_instr, 32'h13);
    check("s5c1.req", f1.o_req_addr, 32'h0);
    cyc();
    exp_out("s1c2", 1'b1, 32'h4, 32'd2);
    check("s5c2.valid", 32'(f1.o_instr_valid), 32'd1);
    check("s5c2.pc", f1.o_instr_pc, 32'h0);
    check("s5c2.instr", f1.o_instr, 32'd1);
    cyc();
    exp_out("s1c3", 1'b1, 32'h8, 32'd3);
    cyc();
    exp_out("s1c4", 1'b1, 32'hC, 32'd4);
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    exp_out("s2pre", 1'b1, 32'h8, 32'd3);
    f0.i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      exp_out($sformatf("s2hold%0d", i), 1'b1, 32'h8, 32'd3);
      check($sformatf("s2hold%0d.req", i), f0.o_req_addr, 32'hC);
    end
    f0.i_stall = 1'b0;
    cyc();
    exp_out("s2rel1", 1'b1, 32'hC, 32'd4);
    cyc();
    exp_out("s2rel2", 1'b1, 32'h10, 32'd5);
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    exp_out("s3pre", 1'b1, 32'h8, 32'd3);
    f0.i_redirect_valid = 1'b1;
    f0.i_redirect_addr = 32'h40;
    cyc();
    f0.i_redirect_valid = 1'b0;
    check("s3bub.valid", 32'(f0.o_instr_valid), 32'd0);
    check("s3bub.instr", f0.o_instr, 32'h13);
    check("s3bub.req", f0.o_req_addr, 32'h40);
    cyc();
    exp_out("s3t1", 1'b1, 32'h40, 32'd17);
    cyc();
    exp_out("s3t2", 1'b1, 32'h44, 32'd18);
`ifdef FETCH_PERF_EN
    check("s6.bubble_cnt", f0.o_bubble_cnt, 32'd2);
    check("s6.fetch_cnt", f0.o_fetch_cnt, 32'd4);
`endif
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    f0.i_stall = 1'b1;
    cyc();
    exp_out("s4skid", 1'b1, 32'h8, 32'd3);
    f0.i_redirect_valid = 1'b1;
    f0.i_redirect_addr = 32'h43;
    cyc();
    f0.i_stall = 1'b0;
    f0.i_redirect_valid = 1'b0;
    check("s4bub.valid", 32'(f0.o_instr_valid), 32'd0);
    check("s4bub.instr", f0.o_instr, 32'h13);
    check("s4bub.req", f0.o_req_addr, 32'h40);
    cyc();
    exp_out("s4t1", 1'b1, 32'h40, 32'd17);
    cyc();
    exp_out("s4t2", 1'b1, 32'h44, 32'd18);
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    f0.i_stall = 1'b1;
    cyc();
    exp_out("s7skid", 1'b1, 32'h8, 32'd3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_out("s7rst", 1'b0, 32'h0, 32'h13);
    f0.i_stall = 1'b0;
    cyc();
    exp_out("s7t1", 1'b1, 32'h0, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
